// File: rtl/iobuf_halfduplex_ctrl_pkg.sv
// Package iobuf_hd_pkg: shared definitions for the half-duplex pad-bus controller.
//   hd_state_t : 2-bit controller state encoding (LISTEN, TURN_TX, DRIVE, TURN_RX)
//   cnt_width  : width of a counter that must hold the values 0..max_count
package iobuf_hd_pkg;

   typedef enum logic [1:0] {
      LISTEN  = 2'd0,
      TURN_TX = 2'd1,
      DRIVE   = 2'd2,
      TURN_RX = 2'd3
   } hd_state_t;

   function automatic int cnt_width(input int max_count);
      return (max_count < 2) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/iobuf_halfduplex_ctrl_if.sv
// Interface iobuf_halfduplex_ctrl_if: the TX handshake, RX delivery and IOBUF pad
// signals of one half-duplex controller.
//   TX_DATA/TX_VALID/TX_READY : word source handshake
//   RX_DATA/RX_VALID          : sampled words, one-cycle valid pulse
//   SAMPLE_EN                 : peer strobe qualifying sampling while listening
//   FORCE_HIZ                 : global tri-state override
//   PAD_I/PAD_T/PAD_O         : IOBUF I, T (1 = high-Z) and O
// modport slave  : the controller side
// modport master : the user / pad side
interface iobuf_halfduplex_ctrl_if #(
   parameter int W = 8
);
   logic [W-1:0] TX_DATA;
   logic         TX_VALID;
   logic         TX_READY;
   logic [W-1:0] RX_DATA;
   logic         RX_VALID;
   logic         SAMPLE_EN;
   logic         FORCE_HIZ;
   logic [W-1:0] PAD_I;
   logic         PAD_T;
   logic [W-1:0] PAD_O;

   modport slave (
      input  TX_DATA, TX_VALID, SAMPLE_EN, FORCE_HIZ, PAD_O,
      output TX_READY, RX_DATA, RX_VALID, PAD_I, PAD_T
   );

   modport master (
      output TX_DATA, TX_VALID, SAMPLE_EN, FORCE_HIZ, PAD_O,
      input  TX_READY, RX_DATA, RX_VALID, PAD_I, PAD_T
   );
endinterface

// File: rtl/iobuf_halfduplex_ctrl_rx_stage.sv
// Module iobuf_hd_rx_stage: captures PAD_O into RX_DATA when a sample is requested.
// Build option: IOBUF_RXREG2_EN defined inserts a second register stage (latency 2);
// undefined gives a single stage (latency 1).
//   clk      in  clock
//   srst     in  synchronous active-high reset, clears every stage
//   sample   in  take PAD_O this cycle
//   pad_o    in  W-bit bus value
//   rx_data  out last delivered word (holds between samples)
//   rx_valid out one-cycle pulse per delivered word
module iobuf_hd_rx_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         sample,
   input  logic [W-1:0] pad_o,
   output logic [W-1:0] rx_data,
   output logic         rx_valid
);

   logic         load;
   logic [W-1:0] load_data;
   logic [W-1:0] rx_data_reg;
   logic         rx_valid_reg;

`ifdef IOBUF_RXREG2_EN
   logic [W-1:0] s1_data_reg;
   logic         s1_valid_reg;

   // First stage runs regardless of controller state so a sample taken on
   // the last LISTEN cycle still reaches the output.
   always_ff @(posedge clk) begin
      if (srst) begin
         s1_data_reg  <= '0;
         s1_valid_reg <= 1'b0;
      end else begin
         s1_valid_reg <= sample;
         if (sample) begin
            s1_data_reg <= pad_o;
         end
      end
   end

   assign load      = s1_valid_reg;
   assign load_data = s1_data_reg;
`else
   assign load      = sample;
   assign load_data = pad_o;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_rx_bit
         always_ff @(posedge clk) begin
            if (srst) begin
               rx_data_reg[gi] <= 1'b0;
            end else if (load) begin
               rx_data_reg[gi] <= load_data[gi];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (srst) begin
         rx_valid_reg <= 1'b0;
      end else begin
         rx_valid_reg <= load;
      end
   end

   assign rx_data  = rx_data_reg;
   assign rx_valid = rx_valid_reg;

endmodule

// File: rtl/iobuf_halfduplex_ctrl.sv
// Module iobuf_halfduplex_ctrl: half-duplex controller for a shared W-bit tri-state
// pad bus built from per-bit IOBUF cells. Listens (samples PAD_O on SAMPLE_EN),
// turns the bus around with TURN_CYCLES dead cycles, drives up to MAX_BURST TX
// beats, then turns back.
// Build option: IOBUF_RXREG2_EN adds a second RX register stage (RX latency 2).
//   C    in  clock, rising edge
//   R    in  synchronous active-high reset
//   bus  slave modport of iobuf_halfduplex_ctrl_if (TX handshake, RX, pads)
module iobuf_halfduplex_ctrl
   import iobuf_hd_pkg::*;
#(
   parameter int W           = 8,
   parameter int TURN_CYCLES = 2,
   parameter int MAX_BURST   = 16
) (
   input  logic                    C,
   input  logic                    R,
   iobuf_halfduplex_ctrl_if.slave  bus
);

   localparam int TW = cnt_width(TURN_CYCLES);
   localparam int BW = cnt_width(MAX_BURST);
   localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYCLES - 1);
   localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

   hd_state_t     state_reg,     state_next;
   logic [TW-1:0] turn_cnt_reg,  turn_cnt_next;
   logic [BW-1:0] burst_cnt_reg, burst_cnt_next;
   logic          pad_t_reg;
   logic [W-1:0]  pad_i_reg;

   logic in_drive;
   logic accept;
   logic turn_done;
   logic sample;

   assign in_drive  = (state_reg == DRIVE);
   assign accept    = in_drive & ~bus.FORCE_HIZ & bus.TX_VALID;
   assign turn_done = (turn_cnt_reg == TURN_LAST);
   assign sample    = (state_reg == LISTEN) & bus.SAMPLE_EN;

   // FORCE_HIZ in DRIVE freezes everything: no beat, no exit, counters hold.
   always_comb begin
      state_next     = state_reg;
      turn_cnt_next  = turn_cnt_reg;
      burst_cnt_next = burst_cnt_reg;
      case (state_reg)
         LISTEN: begin
            if (bus.TX_VALID) begin
               state_next    = TURN_TX;
               turn_cnt_next = '0;
            end
         end
         TURN_TX: begin
            if (turn_done) begin
               state_next     = DRIVE;
               turn_cnt_next  = '0;
               burst_cnt_next = '0;
            end else begin
               turn_cnt_next = turn_cnt_reg + 1'b1;
            end
         end
         DRIVE: begin
            if (!bus.FORCE_HIZ) begin
               if (!bus.TX_VALID) begin
                  state_next    = TURN_RX;
                  turn_cnt_next = '0;
               end else begin
                  burst_cnt_next = burst_cnt_reg + 1'b1;
                  if (burst_cnt_reg == BURST_LAST) begin
                     state_next    = TURN_RX;
                     turn_cnt_next = '0;
                  end
               end
            end
         end
         TURN_RX: begin
            if (turn_done) begin
               state_next    = LISTEN;
               turn_cnt_next = '0;
            end else begin
               turn_cnt_next = turn_cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next    = LISTEN;
            turn_cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge C) begin
      if (R) begin
         state_reg     <= LISTEN;
         turn_cnt_reg  <= '0;
         burst_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         turn_cnt_reg  <= turn_cnt_next;
         burst_cnt_reg <= burst_cnt_next;
      end
   end

   // Pad enable is a flop mirroring "next state is DRIVE" so PAD_T has no
   // decode logic between the state register and the IOBUF T pin.
   always_ff @(posedge C) begin
      if (R) begin
         pad_t_reg <= 1'b1;
         pad_i_reg <= '0;
      end else begin
         pad_t_reg <= (state_next != DRIVE);
         if (accept) begin
            pad_i_reg <= bus.TX_DATA;
         end
      end
   end

   iobuf_hd_rx_stage #(
      .W (W)
   ) u_rx_stage (
      .clk      (C),
      .srst     (R),
      .sample   (sample),
      .pad_o    (bus.PAD_O),
      .rx_data  (bus.RX_DATA),
      .rx_valid (bus.RX_VALID)
   );

   // FORCE_HIZ acts combinationally on the pad, like a global tri-state.
   assign bus.PAD_T    = pad_t_reg | bus.FORCE_HIZ;
   assign bus.PAD_I    = pad_i_reg;
   assign bus.TX_READY = in_drive & ~bus.FORCE_HIZ;

endmodule
